instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low, with ports named clk and rst_n.
REQ-002 Parameter ADDR_W, default 8, SHALL set the instruction-memory address and PC width.
REQ-003 Parameter INSTR_W, default 16, SHALL set the instruction and IR width.
REQ-004 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  async active-low reset.
REQ-007 fetch_req  in  1  controller request for the next instruction.
REQ-008 jmp_en  in  1  load PC from jmp_addr.
REQ-009 jmp_cond  in  1  1 = jump only when z=1; 0 = unconditional jump.
REQ-010 z  in  1  ALU zero flag.
REQ-011 jmp_addr  in  ADDR_W  jump target.
REQ-012 imem_rdata  in  INSTR_W  instruction memory data, valid one cycle after imem_rd.
REQ-013 imem_addr  out  ADDR_W  instruction memory address.
REQ-014 imem_rd  out  1  memory read strobe.
REQ-015 IR  out  INSTR_W  instruction register, feeds the controller.
REQ-016 ir_valid  out  1  IR holds a fetched, unflushed instruction.
REQ-017 pc  out  ADDR_W  address of the next instruction to fetch.
REQ-018 busy  out  1  fetch in flight; new requests are ignored.

Function
REQ-019 The FSM SHALL have states IDLE, RD, CAP, HOLD; all outputs SHALL be registered.
REQ-020 In IDLE or HOLD, fetch_req=1 at edge T SHALL enter RD; in RD, imem_rd=1 and imem_addr=pc.
REQ-021 RD SHALL always go to CAP; at the CAP-exit edge, IR<=imem_rdata, pc<=pc+1, ir_valid<=1, and the next state SHALL be HOLD.
REQ-022 busy SHALL be 1 exactly in RD and CAP; fetch_req and jmp_en SHALL be ignored while busy=1.
REQ-023 In IDLE or HOLD, jmp_en=1 SHALL be taken when jmp_cond=0 or z=1; a taken jump SHALL set pc<=jmp_addr and ir_valid<=0, and SHALL leave IR unchanged.
REQ-024 A not-taken conditional jump SHALL leave pc and ir_valid unchanged.
REQ-025 With jmp_en and fetch_req in the same cycle, the jump SHALL apply first and the fetch SHALL read from jmp_addr (RD issued with imem_addr=jmp_addr).
REQ-026 PC increment SHALL wrap from 2^ADDR_W-1 to 0 without any flag.
REQ-027 Without fetch_req, HOLD SHALL remain in HOLD with IR stable.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, IR=0, ir_valid=0, imem_rd=0, imem_addr=0, busy=0, including mid-fetch; the in-flight read data SHALL be discarded.
REQ-029 After rst_n deasserts, the first fetch SHALL read RESET_PC.

Configuration
REQ-030 Macro INSTR_FETCH_PREFETCH_EN SHALL, when defined, add a one-entry prefetch buffer; when undefined, behaviour SHALL be exactly REQ-019..REQ-027.
REQ-031 With INSTR_FETCH_PREFETCH_EN defined, on entering HOLD the block SHALL autonomously read pc into the buffer, using the same RD/CAP timing.
REQ-032 With INSTR_FETCH_PREFETCH_EN defined, fetch_req with a valid buffer SHALL load IR at the next edge (1-cycle latency), increment pc, and refill the buffer.
REQ-033 With INSTR_FETCH_PREFETCH_EN defined, a taken jump SHALL flush the buffer.

Structure
REQ-034 A shared package SHALL hold the FSM state enum and the default ADDR_W/INSTR_W constants, shared with controller.
REQ-035 Sub-module fetch_pc SHALL implement the PC register: reset, load, and increment with wrap.

Verification
REQ-036 Reset, then pulse fetch_req at cycle 0 with mem[0]=16'h0047 -> imem_rd in cycle 1, IR=16'h0047, ir_valid=1, pc=1 from cycle 3.
REQ-037 In HOLD, drive jmp_en=1, jmp_cond=1, z=0, jmp_addr=8'h20 -> pc and ir_valid unchanged; repeat with z=1 -> pc=8'h20, ir_valid=0.
REQ-038 With jmp_en, fetch_req and jmp_addr=8'h10 in the same cycle -> imem_addr=8'h10 in RD, pc=8'h11 after capture.
REQ-039 With pc=8'hFF, fetch -> pc=8'h00 after capture.
REQ-040 Assert rst_n=0 during CAP -> outputs cleared immediately, IR=0, and the next fetch reads RESET_PC.
REQ-041 With INSTR_FETCH_PREFETCH_EN defined, fetch_req in HOLD with a full buffer -> IR updated one cycle later; a taken jump discards the buffered word.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit and the controller:
// fetch FSM state encoding and default bus widths.
package instr_fetch_pkg;

  localparam int unsigned IF_ADDR_W  = 8;
  localparam int unsigned IF_INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: async reset to RESET_PC, load has priority over
// increment, increment wraps silently at 2^ADDR_W.
module fetch_pc
  import instr_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = IF_ADDR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: jump target, sequential increment, or hold.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_o_w();

  function automatic logic [ADDR_W-1:0] pc_o_w();
    return pc_q;
  endfunction

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE -> RD -> CAP -> HOLD fetch FSM with
// registered memory strobe/address, IR and status outputs, plus jump handling.
// Optional macro INSTR_FETCH_PREFETCH_EN adds a one-entry prefetch buffer
// that is filled autonomously from HOLD and flushed by a taken jump.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IF_ADDR_W,
  parameter int unsigned       INSTR_W  = IF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic               jmp_en,
  input  logic               jmp_cond,
  input  logic               z,
  input  logic [ADDR_W-1:0]  jmp_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  output logic [INSTR_W-1:0] IR,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy
);

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] ir_q;
  logic               ir_valid_q;
  logic               imem_rd_q;
  logic [ADDR_W-1:0]  imem_addr_q;
  logic               busy_q;

  logic               idle_or_hold;
  logic               jmp_taken;
  logic               start_rd;
  logic               pc_inc;
  logic [ADDR_W-1:0]  rd_addr_d;
  logic [ADDR_W-1:0]  pc_w;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic [INSTR_W-1:0] buf_q;
  logic               buf_valid_q;
  logic               pf_q;
  logic               buf_hit;
  logic               start_pf;
`endif

  // Decode jump/fetch decisions; a taken jump redirects the read address
  // in the same cycle so a simultaneous fetch reads from the target.
  always_comb begin
    idle_or_hold = (state_q == IDLE) || (state_q == HOLD);
    jmp_taken    = idle_or_hold && jmp_en && (!jmp_cond || z);
    rd_addr_d    = jmp_taken ? jmp_addr : pc_w;
`ifdef INSTR_FETCH_PREFETCH_EN
    buf_hit  = (state_q == HOLD) && buf_valid_q && !jmp_taken;
    start_pf = (state_q == HOLD) && !fetch_req && (!buf_valid_q || jmp_taken);
    start_rd = idle_or_hold && ((fetch_req && !buf_hit) || start_pf);
    pc_inc   = ((state_q == CAP) && !pf_q) || (fetch_req && buf_hit);
`else
    start_rd = idle_or_hold && fetch_req;
    pc_inc   = (state_q == CAP);
`endif
  end

  // Fetch FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      imem_rd_q   <= 1'b0;
      imem_addr_q <= '0;
      busy_q      <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      pf_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (jmp_taken) ir_valid_q <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
          if (jmp_taken) buf_valid_q <= 1'b0;
          if (fetch_req && buf_hit) begin
            ir_q        <= buf_q;
            ir_valid_q  <= 1'b1;
            buf_valid_q <= 1'b0;
          end
          pf_q <= start_pf;
`endif
          if (start_rd) begin
            state_q     <= RD;
            imem_rd_q   <= 1'b1;
            imem_addr_q <= rd_addr_d;
            busy_q      <= 1'b1;
          end
        end
        RD: begin
          imem_rd_q <= 1'b0;
          state_q   <= CAP;
        end
        CAP: begin
          state_q <= HOLD;
          busy_q  <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
          // A prefetch read lands in the buffer, a demand read lands in IR.
          if (pf_q) begin
            buf_q       <= imem_rdata;
            buf_valid_q <= 1'b1;
          end else begin
            ir_q       <= imem_rdata;
            ir_valid_q <= 1'b1;
          end
          pf_q <= 1'b0;
`else
          ir_q       <= imem_rdata;
          ir_valid_q <= 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (jmp_taken),
    .load_val_i (jmp_addr),
    .inc_i      (pc_inc),
    .pc_o       (pc_w)
  );

  assign imem_addr = imem_addr_q;
  assign imem_rd   = imem_rd_q;
  assign IR        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign pc        = pc_w;
  assign busy      = busy_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected read addresses
// and capture results; a negedge monitor pops and compares them whenever the
// DUT issues a read or finishes a fetch.
module tb_instr_fetch;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic          jmp_en = 1'b0;
  logic          jmp_cond = 1'b0;
  logic          z = 1'b0;
  logic [AW-1:0] jmp_addr = '0;
  logic [IW-1:0] imem_rdata;
  logic [AW-1:0] imem_addr;
  logic          imem_rd;
  logic [IW-1:0] IR;
  logic          ir_valid;
  logic [AW-1:0] pc;
  logic          busy;

  logic [IW-1:0] mem [0:255];

  typedef struct packed {
    logic [IW-1:0] ir;
    logic [AW-1:0] pc;
  } cap_t;

  logic [AW-1:0] exp_addr_q [$];
  cap_t          exp_cap_q  [$];

  int n_tests = 0;
  int n_fail  = 0;
  logic prev_busy = 1'b0;

  instr_fetch #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .RESET_PC (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .jmp_en     (jmp_en),
    .jmp_cond   (jmp_cond),
    .z          (z),
    .jmp_addr   (jmp_addr),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .IR         (IR),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data valid the cycle after the read strobe.
  always @(posedge clk) if (imem_rd) imem_rdata <= mem[imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 20) begin
      step();
      k++;
    end
    chk("fetch_done_bound", {31'b0, busy}, 32'd0);
  endtask

  task automatic do_fetch(input logic [AW-1:0] a, input logic [IW-1:0] d, input logic [AW-1:0] npc);
    exp_addr_q.push_back(a);
    exp_cap_q.push_back('{ir: d, pc: npc});
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    wait_idle();
  endtask

  // Monitor: compare every read address and every completed fetch.
  initial begin : monitor
    logic [AW-1:0] ea;
    cap_t          ec;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        if (imem_rd) begin
          if (exp_addr_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rd_unexpected: got read of %h expected no read", imem_addr);
          end else begin
            ea = exp_addr_q.pop_front();
            chk("rd_addr", {24'b0, imem_addr}, {24'b0, ea});
          end
        end
`ifndef INSTR_FETCH_PREFETCH_EN
        if (prev_busy && !busy) begin
          if (exp_cap_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL cap_unexpected: got capture IR=%h expected none", IR);
          end else begin
            ec = exp_cap_q.pop_front();
            chk("cap_ir", {16'b0, IR}, {16'b0, ec.ir});
            chk("cap_pc", {24'b0, pc}, {24'b0, ec.pc});
            chk("cap_valid", {31'b0, ir_valid}, 32'd1);
          end
        end
`endif
        prev_busy = busy;
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
    mem[0]     = 16'h0047;
    mem[8'hFF] = 16'hBEEF;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", {24'b0, pc}, 32'h00);
    chk("rst_ir", {16'b0, IR}, 32'h0);
    chk("rst_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_rd", {31'b0, imem_rd}, 32'd0);
    chk("rst_addr", {24'b0, imem_addr}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;

`ifndef INSTR_FETCH_PREFETCH_EN
    // First fetch with exact latency: RD in cycle 1, result from cycle 3.
    exp_addr_q.push_back(8'h00);
    exp_cap_q.push_back('{ir: 16'h0047, pc: 8'h01});
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("c1_rd", {31'b0, imem_rd}, 32'd1);
    chk("c1_busy", {31'b0, busy}, 32'd1);
    step();
    chk("c2_rd", {31'b0, imem_rd}, 32'd0);
    chk("c2_valid", {31'b0, ir_valid}, 32'd0);
    step();
    chk("c3_ir", {16'b0, IR}, 32'h0047);
    chk("c3_valid", {31'b0, ir_valid}, 32'd1);
    chk("c3_pc", {24'b0, pc}, 32'h01);
    chk("c3_busy", {31'b0, busy}, 32'd0);

    // Conditional jump: not taken with z=0, taken with z=1.
    jmp_en = 1'b1; jmp_cond = 1'b1; z = 1'b0; jmp_addr = 8'h20;
    step();
    chk("nt_pc", {24'b0, pc}, 32'h01);
    chk("nt_valid", {31'b0, ir_valid}, 32'd1);
    z = 1'b1;
    step();
    jmp_en = 1'b0; jmp_cond = 1'b0; z = 1'b0;
    chk("tk_pc", {24'b0, pc}, 32'h20);
    chk("tk_valid", {31'b0, ir_valid}, 32'd0);
    chk("tk_ir", {16'b0, IR}, 32'h0047);

    // Jump and fetch together: read comes from the jump target.
    exp_addr_q.push_back(8'h10);
    exp_cap_q.push_back('{ir: 16'hC010, pc: 8'h11});
    jmp_en = 1'b1; jmp_addr = 8'h10; fetch_req = 1'b1;
    step();
    jmp_en = 1'b0; fetch_req = 1'b0;
    chk("jf_addr", {24'b0, imem_addr}, 32'h10);
    chk("jf_valid", {31'b0, ir_valid}, 32'd0);
    wait_idle();

    // PC wrap from FF to 00.
    jmp_en = 1'b1; jmp_addr = 8'hFF;
    step();
    jmp_en = 1'b0;
    do_fetch(8'hFF, 16'hBEEF, 8'h00);

    // HOLD without request keeps IR stable.
    repeat (3) step();
    chk("hold_ir", {16'b0, IR}, 32'hBEEF);
    chk("hold_pc", {24'b0, pc}, 32'h00);
    chk("hold_busy", {31'b0, busy}, 32'd0);

    // Requests and jumps during RD/CAP are ignored.
    exp_addr_q.push_back(8'h00);
    exp_cap_q.push_back('{ir: 16'h0047, pc: 8'h01});
    fetch_req = 1'b1;
    step();
    jmp_en = 1'b1; jmp_addr = 8'h55;
    step();
    step();
    fetch_req = 1'b0; jmp_en = 1'b0;
    chk("ign_pc", {24'b0, pc}, 32'h01);
    chk("ign_ir", {16'b0, IR}, 32'h0047);

    // Reset during CAP discards the read; next fetch reads RESET_PC.
    exp_addr_q.push_back(8'h01);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", {31'b0, busy}, 32'd0);
    chk("mr_ir", {16'b0, IR}, 32'h0);
    chk("mr_valid", {31'b0, ir_valid}, 32'd0);
    chk("mr_pc", {24'b0, pc}, 32'h00);
    chk("mr_rd", {31'b0, imem_rd}, 32'd0);
    chk("mr_addr", {24'b0, imem_addr}, 32'h0);
    step();
    rst_n = 1'b1;
    do_fetch(8'h00, 16'h0047, 8'h01);
    repeat (2) step();
    chk("cap_q_empty", exp_cap_q.size(), 32'd0);
`else
    // Prefetch build: demand fetch, autonomous buffer fill, 1-cycle hit,
    // then a taken jump that must discard the buffered word.
    exp_addr_q.push_back(8'h00);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    repeat (2) step();
    chk("pf_ir0", {16'b0, IR}, 32'h0047);
    exp_addr_q.push_back(8'h01);
    repeat (3) step();
    chk("pf_busy", {31'b0, busy}, 32'd0);
    exp_addr_q.push_back(8'h02);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("pf_hit_ir", {16'b0, IR}, 32'hC001);
    chk("pf_hit_pc", {24'b0, pc}, 32'h02);
    chk("pf_hit_valid", {31'b0, ir_valid}, 32'd1);
    repeat (3) step();
    exp_addr_q.push_back(8'h20);
    jmp_en = 1'b1; jmp_addr = 8'h20;
    step();
    jmp_en = 1'b0;
    chk("pf_jmp_pc", {24'b0, pc}, 32'h20);
    chk("pf_jmp_valid", {31'b0, ir_valid}, 32'd0);
    repeat (2) step();
    exp_addr_q.push_back(8'h21);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("pf_flush_ir", {16'b0, IR}, 32'hC020);
    chk("pf_flush_pc", {24'b0, pc}, 32'h21);
    repeat (4) step();
`endif
    chk("addr_q_empty", exp_addr_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
